// File: rtl/wb_bram_port.sv
// wb_bram_port: Wishbone B4 pipelined slave driving one block-RAM port.
// Full words stream at one per clock; partial writes use read-modify-write.
module wb_bram_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_wb_cyc,
    input  logic                    i_wb_stb,
    input  logic                    i_wb_we,
    input  logic [ADDR_WIDTH-1:0]   i_wb_addr,
    input  logic [DATA_WIDTH-1:0]   i_wb_data,
    input  logic [DATA_WIDTH/8-1:0] i_wb_sel,
    output logic                    o_wb_stall,
    output logic                    o_wb_ack,
    output logic [DATA_WIDTH-1:0]   o_wb_data,
    output logic                    o_en,
    output logic                    o_we,
    output logic [ADDR_WIDTH-1:0]   o_addr,
    output logic [DATA_WIDTH-1:0]   o_din,
    input  logic [DATA_WIDTH-1:0]   i_dout
);

    localparam int SelWidth = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        RMW_RD,
        RMW_MRG,
        RMW_WR
    } state_t;

    // Per-request tracking through the two-cycle RAM latency.
    typedef struct packed {
        logic valid;
        logic isRead;
    } tag_t;

    state_t state;
    state_t stateNext;

    tag_t tag1;
    tag_t tag2;

    logic accept;
    logic selFull;
    logic selNone;
    logic isRead;
    logic isFullWr;
    logic isNullWr;
    logic isPartWr;

    logic [ADDR_WIDTH-1:0] rmwAddr;
    logic [DATA_WIDTH-1:0] rmwData;
    logic [SelWidth-1:0]   rmwSel;
    logic [DATA_WIDTH-1:0] merged;

    logic                  enD;
    logic                  weD;
    logic [ADDR_WIDTH-1:0] addrD;
    logic [DATA_WIDTH-1:0] dinD;

    // Classify the request presented this cycle; only one class is live.
    always_comb begin
        accept   = i_wb_cyc & i_wb_stb & ~o_wb_stall;
        selFull  = &i_wb_sel;
        selNone  = ~|i_wb_sel;
        isRead   = accept & ~i_wb_we;
        isFullWr = accept & i_wb_we & selFull;
        isNullWr = accept & i_wb_we & selNone;
        isPartWr = accept & i_wb_we & ~selFull & ~selNone;
    end

    // Byte merge of the latched write data over the word just read back.
    always_comb begin
        merged = '0;
        for (int k = 0; k < SelWidth; k++) begin
            merged[8*k +: 8] = rmwSel[k] ? rmwData[8*k +: 8]
                                         : i_dout[8*k +: 8];
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next state; dropping the cycle abandons an unissued RMW write.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (isPartWr) stateNext = RMW_RD;
            RMW_RD:  stateNext = i_wb_cyc ? RMW_MRG : IDLE;
            RMW_MRG: stateNext = i_wb_cyc ? RMW_WR : IDLE;
            RMW_WR:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // FSM outputs: next value of the RAM port request.
    always_comb begin
        enD   = 1'b0;
        weD   = 1'b0;
        addrD = o_addr;
        dinD  = o_din;
        unique case (1'b1)
            (state == RMW_MRG) && i_wb_cyc: begin
                enD   = 1'b1;
                weD   = 1'b1;
                addrD = rmwAddr;
                dinD  = merged;
            end
            isRead || isFullWr: begin
                enD   = 1'b1;
                weD   = i_wb_we;
                addrD = i_wb_addr;
                dinD  = i_wb_data;
            end
            isPartWr: begin
                enD   = 1'b1;
                weD   = 1'b0;
                addrD = i_wb_addr;
            end
            default: ;
        endcase
    end

    // Registered RAM port and stall.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_en       <= 1'b0;
            o_we       <= 1'b0;
            o_addr     <= '0;
            o_din      <= '0;
            o_wb_stall <= 1'b0;
        end else begin
            o_en       <= enD;
            o_we       <= weD;
            o_addr     <= addrD;
            o_din      <= dinD;
            o_wb_stall <= (stateNext != IDLE);
        end
    end

    // Hold the partial write while the old word is fetched.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rmwAddr <= '0;
            rmwData <= '0;
            rmwSel  <= '0;
        end else if (isPartWr) begin
            rmwAddr <= i_wb_addr;
            rmwData <= i_wb_data;
            rmwSel  <= i_wb_sel;
        end
    end

    // Ack pipeline; an abort flushes every outstanding ack.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tag1      <= '0;
            tag2      <= '0;
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else if (!i_wb_cyc) begin
            tag1     <= '0;
            tag2     <= '0;
            o_wb_ack <= 1'b0;
        end else begin
            tag1.valid  <= isRead | isFullWr | isNullWr;
            tag1.isRead <= isRead;
            tag2        <= tag1;
            o_wb_ack    <= tag2.valid | (state == RMW_WR);
            if (tag2.valid && tag2.isRead) begin
                o_wb_data <= i_dout;
            end
        end
    end

endmodule

// File: tb/tb_wb_bram_port.sv
// tb_wb_bram_port: directed and random bus traffic against a memory
// model that predicts acks, read data, stall and RAM port activity.
module tb_wb_bram_port;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int Depth = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wbCyc = 1'b0;
    logic          wbStb = 1'b0;
    logic          wbWe = 1'b0;
    logic [AW-1:0] wbAddr = '0;
    logic [DW-1:0] wbData = '0;
    logic [3:0]    wbSel = '0;
    logic          wbStall;
    logic          wbAck;
    logic [DW-1:0] wbRdata;
    logic          ramEn;
    logic          ramWe;
    logic [AW-1:0] ramAddr;
    logic [DW-1:0] ramDin;
    logic [DW-1:0] ramDout = '0;
    logic [DW-1:0] ram [Depth];

    typedef struct {
        int          due;
        bit          isRead;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          expQ[$];
    logic [DW-1:0] refMem [Depth];
    int            edgeNo = 0;
    int            busyUntil = 0;
    bit            rmwPending = 0;
    int            rmwEdge = 0;
    logic [AW-1:0] rmwAddr = '0;
    logic [DW-1:0] rmwOld = '0;
    logic [DW-1:0] rmwNew = '0;
    logic [DW-1:0] lastData = '0;
    int            nTests = 0;
    int            nFail = 0;

    wb_bram_port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_wb_cyc  (wbCyc),
        .i_wb_stb  (wbStb),
        .i_wb_we   (wbWe),
        .i_wb_addr (wbAddr),
        .i_wb_data (wbData),
        .i_wb_sel  (wbSel),
        .o_wb_stall(wbStall),
        .o_wb_ack  (wbAck),
        .o_wb_data (wbRdata),
        .o_en      (ramEn),
        .o_we      (ramWe),
        .o_addr    (ramAddr),
        .o_din     (ramDin),
        .i_dout    (ramDout)
    );

    always #5 clk = ~clk;

    // Read-first single-port block RAM.
    always @(posedge clk) begin
        if (ramEn) begin
            if (ramWe) ram[ramAddr] <= ramDin;
            ramDout <= ram[ramAddr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     tag, got, exp, edgeNo);
        end
    endtask

    function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] old,
                                                 input logic [DW-1:0] nw,
                                                 input logic [3:0] sel);
        logic [DW-1:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) r[8*k +: 8] = nw[8*k +: 8];
        end
        return r;
    endfunction

    // One clock of bus stimulus, model update and output checks.
    task automatic step(input bit c, input bit s, input bit w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] sel);
        bit            acc;
        bit            expAck;
        bit            expEn;
        bit            expWe;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expDin;
        wbCyc  = c;
        wbStb  = s;
        wbWe   = w;
        wbAddr = a;
        wbData = d;
        wbSel  = sel;
        acc = c && s && !(edgeNo < busyUntil);
        @(posedge clk);
        edgeNo++;
        expEn   = 0;
        expWe   = 0;
        expAddr = '0;
        expDin  = '0;
        if (!c) begin
            expQ.delete();
            if (rmwPending && edgeNo <= rmwEdge + 2)
                refMem[rmwAddr] = rmwOld;
            rmwPending = 0;
            busyUntil  = 0;
        end else if (rmwPending && edgeNo == rmwEdge + 2) begin
            expEn   = 1;
            expWe   = 1;
            expAddr = rmwAddr;
            expDin  = rmwNew;
        end
        if (acc) begin
            expEn   = 1;
            expAddr = a;
            expWe   = w;
            if (!w) begin
                expQ.push_back('{due: edgeNo + 2, isRead: 1'b1,
                                 data: refMem[a]});
            end else if (sel == 4'hF) begin
                refMem[a] = d;
                expDin = d;
                expQ.push_back('{due: edgeNo + 2, isRead: 1'b0, data: '0});
            end else if (sel == 4'h0) begin
                expEn = 0;
                expQ.push_back('{due: edgeNo + 2, isRead: 1'b0, data: '0});
            end else begin
                rmwOld     = refMem[a];
                rmwNew     = mergeBytes(rmwOld, d, sel);
                refMem[a]  = rmwNew;
                rmwAddr    = a;
                rmwEdge    = edgeNo;
                rmwPending = 1;
                busyUntil  = edgeNo + 3;
                expWe      = 0;
                expQ.push_back('{due: edgeNo + 3, isRead: 1'b0, data: '0});
            end
        end
        if (rmwPending && edgeNo >= rmwEdge + 3) rmwPending = 0;
        #1;
        expAck = (expQ.size() > 0) && (expQ[0].due == edgeNo);
        check("ack", wbAck, expAck);
        if (expAck && expQ[0].isRead) lastData = expQ[0].data;
        while (expQ.size() > 0 && expQ[0].due <= edgeNo)
            void'(expQ.pop_front());
        check("rdata", wbRdata, lastData);
        check("stall", wbStall, edgeNo < busyUntil);
        check("ramEn", ramEn, expEn);
        if (expEn) begin
            check("ramWe", ramWe, expWe);
            check("ramAddr", ramAddr, expAddr);
            if (expWe) check("ramDin", ramDin, expDin);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 0, 0, '0, '0, 4'h0);
    endtask

    task automatic checkResetOutputs();
        check("rst_stall", wbStall, 0);
        check("rst_ack", wbAck, 0);
        check("rst_data", wbRdata, 0);
        check("rst_en", ramEn, 0);
        check("rst_we", ramWe, 0);
        check("rst_addr", ramAddr, 0);
        check("rst_din", ramDin, 0);
    endtask

    task automatic clearModel();
        expQ.delete();
        busyUntil  = 0;
        rmwPending = 0;
        lastData   = '0;
    endtask

    initial begin
        bit            c;
        bit            s;
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0]    sel;
        int            pick;

        for (int i = 0; i < Depth; i++) begin
            ram[i]    = '0;
            refMem[i] = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs();
        rst = 1'b0;

        step(1, 1, 1, 10'h001, 32'hDEADBEEF, 4'hF);
        step(1, 1, 0, 10'h001, 32'h0, 4'hF);
        idle(3);

        for (int n = 0; n < 8; n++)
            step(1, 1, 1, 10'h010 + AW'(n), 32'hAAAA0010 + n, 4'hF);
        for (int n = 0; n < 8; n++)
            step(1, 1, 0, 10'h010 + AW'(n), 32'h0, 4'hF);
        idle(3);

        step(1, 1, 1, 10'h020, 32'h11223344, 4'hF);
        step(1, 1, 1, 10'h020, 32'hAABBCCDD, 4'b0101);
        repeat (4) step(1, 1, 0, 10'h020, 32'h0, 4'hF);
        idle(3);

        step(1, 1, 1, 10'h020, 32'h99999999, 4'h0);
        step(1, 1, 0, 10'h020, 32'h0, 4'hF);
        idle(3);

        step(1, 1, 1, 10'h030, 32'h55667788, 4'hF);
        idle(2);
        step(1, 1, 1, 10'h030, 32'hEE000000, 4'b1000);
        step(0, 1, 0, 10'h030, 32'h0, 4'hF);
        idle(3);
        step(1, 1, 0, 10'h030, 32'h0, 4'hF);
        idle(3);

        step(1, 1, 0, 10'h001, 32'h0, 4'hF);
        step(1, 1, 0, 10'h020, 32'h0, 4'hF);
        rst = 1'b1;
        #1;
        checkResetOutputs();
        wbCyc = 0;
        wbStb = 0;
        repeat (2) begin
            @(posedge clk);
            edgeNo++;
        end
        #1;
        rst = 1'b0;
        clearModel();
        idle(4);
        step(1, 1, 0, 10'h014, 32'h0, 4'hF);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            c = ($urandom_range(19) != 0);
            s = ($urandom_range(3) != 0);
            w = $urandom_range(1) == 1;
            a = AW'($urandom_range(15));
            d = $urandom;
            pick = $urandom_range(5);
            if (pick < 2) sel = 4'hF;
            else if (pick == 2) sel = 4'h0;
            else sel = 4'($urandom);
            step(c, s, w, a, d, sel);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
